// File: rtl/query_loader.sv
// Host-to-engine query assembler: deserializes a toggle-strobed word stream into a
// query vector, k and start vertex, launches the search engine and times its latency.
module query_loader #(
    parameter int          DIM       = 4,
    parameter logic [31:0] SYNC_WORD = 32'hFFFF_FFFF,
    parameter int          CNT_W     = 32
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic [31:0]                word_in,
    input  logic                       seq_in,
    input  logic                       done_in,
    output logic [32*DIM-1:0]          query_out,
    output logic [15:0]                k_out,
    output logic [31:0]                vertex_id_out,
    output logic                       valid_out,
    output logic                       busy_out,
    output logic [31:0]                cycles_out,
    output logic [$clog2(DIM+3)-1:0]   word_count_out
);

    localparam int            CW     = $clog2(DIM + 3);
    localparam logic [CW-1:0] K_SLOT = CW'(DIM);
    localparam logic [CW-1:0] V_SLOT = CW'(DIM + 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        LAUNCH,
        RUN
    } state_t;

    state_t           state;
    logic             seq_q;
    logic [CNT_W-1:0] cycle_cnt;
    logic             strobe;
    logic             is_sync;

    // Every level change of seq_in presents exactly one word.
    assign strobe  = (seq_in != seq_q);
    assign is_sync = (word_in == SYNC_WORD);

    assign cycles_out = 32'(cycle_cnt);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state          <= IDLE;
            seq_q          <= seq_in;
            query_out      <= '0;
            k_out          <= '0;
            vertex_id_out  <= '0;
            valid_out      <= 1'b0;
            busy_out       <= 1'b0;
            cycle_cnt      <= '0;
            word_count_out <= '0;
        end else begin
            seq_q     <= seq_in;
            valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (strobe && is_sync) begin
                        word_count_out <= '0;
                        state          <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (strobe) begin
                        if (is_sync) begin
                            word_count_out <= '0;
                        end else begin
                            for (int i = 0; i < DIM; i++) begin
                                if (word_count_out == CW'(i)) begin
                                    query_out[32*i +: 32] <= word_in;
                                end
                            end
                            if (word_count_out == K_SLOT) begin
                                k_out <= word_in[15:0];
                            end
                            word_count_out <= word_count_out + 1'b1;
                            // The vertex id is the last slot; launch on the next cycle.
                            if (word_count_out == V_SLOT) begin
                                vertex_id_out <= word_in;
                                valid_out     <= 1'b1;
                                busy_out      <= 1'b1;
                                cycle_cnt     <= '0;
                                state         <= LAUNCH;
                            end
                        end
                    end
                end
                LAUNCH: begin
                    state <= RUN;
                end
                RUN: begin
                    if (done_in) begin
                        busy_out <= 1'b0;
                        state    <= IDLE;
                    end else if (cycle_cnt != {CNT_W{1'b1}}) begin
                        cycle_cnt <= cycle_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_query_loader.sv
// Self-checking bench for query_loader: directed scenarios plus randomized frames,
// checked every cycle against a frame-level reference model.
module tb_query_loader;

    localparam int          DIM   = 4;
    localparam logic [31:0] SYNC  = 32'hFFFF_FFFF;
    localparam int          SMALL = 5;
    localparam logic [31:0] SMALL_MAX = 32'd31;

    logic                clk_in = 1'b0;
    logic                rst_in;
    logic [31:0]         word_in;
    logic                seq_in;
    logic                done_in;
    logic [32*DIM-1:0]   query_out;
    logic [15:0]         k_out;
    logic [31:0]         vertex_id_out;
    logic                valid_out;
    logic                busy_out;
    logic [31:0]         cycles_out;
    logic [2:0]          word_count_out;

    logic [32*DIM-1:0]   s_query_out;
    logic [15:0]         s_k_out;
    logic [31:0]         s_vertex_id_out;
    logic                s_valid_out;
    logic                s_busy_out;
    logic [31:0]         s_cycles_out;
    logic [2:0]          s_word_count_out;

    int checks   = 0;
    int failures = 0;
    int valid_pulses = 0;

    always #5 clk_in = ~clk_in;

    query_loader #(.DIM(DIM), .SYNC_WORD(SYNC)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .word_in        (word_in),
        .seq_in         (seq_in),
        .done_in        (done_in),
        .query_out      (query_out),
        .k_out          (k_out),
        .vertex_id_out  (vertex_id_out),
        .valid_out      (valid_out),
        .busy_out       (busy_out),
        .cycles_out     (cycles_out),
        .word_count_out (word_count_out)
    );

    // Narrow-counter variant so saturation is reachable in a short run.
    query_loader #(.DIM(DIM), .SYNC_WORD(SYNC), .CNT_W(SMALL)) dut_small (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .word_in        (word_in),
        .seq_in         (seq_in),
        .done_in        (done_in),
        .query_out      (s_query_out),
        .k_out          (s_k_out),
        .vertex_id_out  (s_vertex_id_out),
        .valid_out      (s_valid_out),
        .busy_out       (s_busy_out),
        .cycles_out     (s_cycles_out),
        .word_count_out (s_word_count_out)
    );

    // Reference model: frame-level bookkeeping of slots, launch and elapsed engine time.
    bit          m_ready = 0;
    bit          m_prev;
    bit          m_in_frame, m_launching, m_engine_running;
    logic [31:0] m_q [DIM];
    logic [15:0] m_k;
    logic [31:0] m_v;
    int          m_cnt;
    logic [31:0] m_cyc;

    always @(posedge clk_in) begin
        bit strobe;
        if (rst_in) begin
            m_ready = 1;
            m_prev = seq_in;
            m_in_frame = 0;
            m_launching = 0;
            m_engine_running = 0;
            for (int i = 0; i < DIM; i++) m_q[i] = 0;
            m_k = 0;
            m_v = 0;
            m_cnt = 0;
            m_cyc = 0;
        end else if (m_ready) begin
            strobe = (seq_in != m_prev);
            m_prev = seq_in;
            if (m_launching) begin
                m_launching = 0;
                m_engine_running = 1;
            end else if (m_engine_running) begin
                if (done_in) m_engine_running = 0;
                else if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
            end else if (strobe) begin
                if (word_in == SYNC) begin
                    m_in_frame = 1;
                    m_cnt = 0;
                end else if (m_in_frame) begin
                    if (m_cnt < DIM) m_q[m_cnt] = word_in;
                    else if (m_cnt == DIM) m_k = word_in[15:0];
                    else m_v = word_in;
                    m_cnt = m_cnt + 1;
                    if (m_cnt == DIM + 2) begin
                        m_in_frame = 0;
                        m_launching = 1;
                        m_cyc = 0;
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_in) begin
        if (m_ready) begin
            if (valid_out) valid_pulses++;
            for (int i = 0; i < DIM; i++)
                checkOutput("query", query_out[32*i +: 32], m_q[i]);
            checkOutput("k", {16'd0, k_out}, {16'd0, m_k});
            checkOutput("vertex", vertex_id_out, m_v);
            checkOutput("valid", {31'd0, valid_out}, {31'd0, m_launching});
            checkOutput("busy", {31'd0, busy_out}, {31'd0, m_launching | m_engine_running});
            checkOutput("cycles", cycles_out, m_cyc);
            checkOutput("word_count", {29'd0, word_count_out}, 32'(m_cnt));
            checkOutput("small_cycles", s_cycles_out, (m_cyc > SMALL_MAX) ? SMALL_MAX : m_cyc);
            checkOutput("small_busy", {31'd0, s_busy_out}, {31'd0, m_launching | m_engine_running});
        end
    end

    task automatic applyStimulus(input logic [31:0] w);
        word_in = w;
        seq_in  = ~seq_in;
        @(posedge clk_in);
        #1;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    // Raises done_in n cycles after the current (launch) cycle, for one cycle.
    task automatic pulseDone(input int n);
        idleCycles(n);
        done_in = 1'b1;
        idleCycles(1);
        done_in = 1'b0;
    endtask

    task automatic sendFrame(input logic [31:0] a, b, c, d, e, f);
        applyStimulus(SYNC);
        applyStimulus(a);
        applyStimulus(b);
        applyStimulus(c);
        applyStimulus(d);
        applyStimulus(e);
        applyStimulus(f);
    endtask

    task automatic checkQuery(input logic [31:0] a, b, c, d, input logic [31:0] k, v);
        checkOutput("lit_q0", query_out[31:0], a);
        checkOutput("lit_q1", query_out[63:32], b);
        checkOutput("lit_q2", query_out[95:64], c);
        checkOutput("lit_q3", query_out[127:96], d);
        checkOutput("lit_k", {16'd0, k_out}, k);
        checkOutput("lit_vertex", vertex_id_out, v);
    endtask

    function automatic logic [31:0] randData();
        logic [31:0] w;
        w = $urandom;
        if (w == SYNC) w = 32'd0;
        return w;
    endfunction

    initial begin
        int v0;
        rst_in  = 1'b1;
        seq_in  = 1'b1;
        word_in = SYNC;
        done_in = 1'b0;
        idleCycles(3);
        rst_in = 1'b0;
        idleCycles(3);
        checkOutput("reset_count", {29'd0, word_count_out}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy_out}, 32'd0);
        checkOutput("reset_cycles", cycles_out, 32'd0);

        // Data without a SYNC must not be collected or launched.
        v0 = valid_pulses;
        for (int i = 0; i < 6; i++) applyStimulus(32'd100 + 32'(i));
        idleCycles(2);
        checkOutput("idle_data_no_launch", 32'(valid_pulses - v0), 32'd0);
        checkOutput("idle_data_count", {29'd0, word_count_out}, 32'd0);

        // Basic frame.
        v0 = valid_pulses;
        sendFrame(5, 7, 1, 1, 4, 9);
        checkOutput("basic_valid", {31'd0, valid_out}, 32'd1);
        checkQuery(5, 7, 1, 1, 4, 9);
        pulseDone(20);
        checkOutput("basic_cycles", cycles_out, 32'd19);
        checkOutput("basic_busy", {31'd0, busy_out}, 32'd0);
        checkOutput("basic_pulses", 32'(valid_pulses - v0), 32'd1);

        // Mid-frame resync, then a full frame strobed during RUN.
        v0 = valid_pulses;
        applyStimulus(SYNC);
        applyStimulus(3);
        applyStimulus(3);
        sendFrame(8, 8, 8, 8, 2, 6);
        checkQuery(8, 8, 8, 8, 2, 6);
        sendFrame(1, 2, 3, 4, 5, 6);
        pulseDone(3);
        checkQuery(8, 8, 8, 8, 2, 6);
        checkOutput("run_ignore_cycles", cycles_out, 32'd9);
        checkOutput("resync_pulses", 32'(valid_pulses - v0), 32'd1);

        // done_in in IDLE is ignored.
        done_in = 1'b1;
        idleCycles(1);
        done_in = 1'b0;
        idleCycles(2);
        checkOutput("idle_done_cycles", cycles_out, 32'd9);

        // Identical words on consecutive-cycle toggles.
        sendFrame(7, 7, 7, 7, 7, 7);
        checkQuery(7, 7, 7, 7, 7, 7);
        checkOutput("repeat_count", {29'd0, word_count_out}, 32'd6);
        pulseDone(5);
        checkOutput("repeat_cycles", cycles_out, 32'd4);

        // Reset mid-RUN.
        sendFrame(1, 2, 3, 4, 10, 11);
        idleCycles(5);
        rst_in = 1'b1;
        idleCycles(1);
        rst_in = 1'b0;
        checkQuery(0, 0, 0, 0, 0, 0);
        checkOutput("rst_busy", {31'd0, busy_out}, 32'd0);
        checkOutput("rst_cycles", cycles_out, 32'd0);
        checkOutput("rst_count", {29'd0, word_count_out}, 32'd0);
        pulseDone(2);
        checkOutput("rst_done_cycles", cycles_out, 32'd0);
        sendFrame(21, 22, 23, 24, 25, 26);
        checkOutput("rst_relaunch", {31'd0, valid_out}, 32'd1);
        checkQuery(21, 22, 23, 24, 25, 26);
        pulseDone(3);
        checkOutput("rst_relaunch_cycles", cycles_out, 32'd2);

        // Long run saturates the narrow counter but not the full one.
        sendFrame(31, 32, 33, 34, 35, 36);
        pulseDone(50);
        checkOutput("sat_full", cycles_out, 32'd49);
        checkOutput("sat_small", s_cycles_out, 32'd31);

        // Randomized frames, with resyncs, gaps and traffic during RUN.
        for (int f = 0; f < 30; f++) begin
            int n;
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) applyStimulus(randData());
            applyStimulus(SYNC);
            if ($urandom_range(0, 3) == 0) begin
                for (int j = 0; j < int'($urandom_range(1, 3)); j++) applyStimulus(randData());
                applyStimulus(SYNC);
            end
            for (int j = 0; j < DIM + 2; j++) begin
                idleCycles(int'($urandom_range(0, 2)));
                applyStimulus(randData());
            end
            n = int'($urandom_range(1, 45));
            for (int j = 0; j < n; j++) begin
                if ($urandom_range(0, 7) == 0) begin
                    word_in = ($urandom_range(0, 1) == 0) ? SYNC : randData();
                    seq_in  = ~seq_in;
                end
                idleCycles(1);
            end
            done_in = 1'b1;
            idleCycles(1);
            done_in = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                done_in = 1'b1;
                idleCycles(1);
                done_in = 1'b0;
            end
            idleCycles(int'($urandom_range(0, 2)));
        end

        idleCycles(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/query_loader.md
# query_loader

Host-to-engine query assembler that sits directly upstream of the `bfis` search engine. It deserializes a 32-bit word stream written by the host debug bridge into a query vector, a `k` value and a start vertex id, then issues a one-cycle launch pulse to `bfis`. It also measures engine latency in clock cycles, from launch to the engine's completion pulse.

## Interface
Parameters:
- `DIM`, 4, number of 32-bit query elements.
- `SYNC_WORD`, 32'hFFFF_FFFF, frame-start marker value.

Ports:
- `clk_in`  in  1  system clock.
- `rst_in`  in  1  synchronous, active-high reset.
- `word_in`  in  32  host data word; must be stable whenever `seq_in` changes.
- `seq_in`  in  1  host strobe; every change of level (0→1 or 1→0) presents one word.
- `done_in`  in  1  engine completion pulse (`bfis` valid_out).
- `query_out`  out  32×DIM  assembled query vector; element i is data word i.
- `k_out`  out  16  `word_in[15:0]` of data word DIM.
- `vertex_id_out`  out  32  data word DIM+1.
- `valid_out`  out  1  one-cycle launch pulse to `bfis`.
- `busy_out`  out  1  high in LAUNCH and RUN.
- `cycles_out`  out  32  measured engine latency.
- `word_count_out`  out  $clog2(DIM+3)  data words captured in the current frame (debug/LED).

## Operation
- Strobe detection: `seq_q` is a registered copy of `seq_in`. `strobe = (seq_in != seq_q)`. During reset, `seq_q <= seq_in`, so no strobe fires on release. `word_in` is sampled in the cycle `strobe` is high.
- SYNC is a strobed word equal to `SYNC_WORD`. Any other strobed word is a data word. SYNC_WORD is never a valid data word.
- States:
  - IDLE: wait. A SYNC moves to COLLECT with `word_count_out` = 0. Data words are ignored.
  - COLLECT: each data word is written to slot `word_count_out`, then the count increments. Slots 0..DIM-1 go to `query_out`, slot DIM to `k_out`, slot DIM+1 to `vertex_id_out`. A SYNC received here restarts the frame: count returns to 0 and stale slots are kept until they are overwritten. The word that fills slot DIM+1 moves the block to LAUNCH.
  - LAUNCH: one cycle. `valid_out`=1, `cycles_out` cleared to 0, then move to RUN.
  - RUN: `cycles_out` increments each cycle while `done_in`=0. It saturates at 32'hFFFF_FFFF and does not wrap. When `done_in`=1, `cycles_out` holds without incrementing and the block moves to IDLE. All strobes, including SYNC, are ignored.
- `query_out`, `k_out` and `vertex_id_out` change only on captured data words. They stay stable through LAUNCH and RUN.
- `cycles_out` holds its last value from RUN exit until the next LAUNCH.
- `done_in` outside RUN is ignored.

## Timing
- Reset values: state IDLE, all outputs 0, `seq_q` = `seq_in`.
- Strobe latency: a `seq_in` edge at cycle T is captured at the rising edge ending cycle T. Slot data is visible at T+1.
- Launch latency: if the final data word is strobed at T, `valid_out` is high during T+1 and `busy_out` rises at T+1.
- The outputs required by `bfis` (`query_out`, `k_out`, `vertex_id_out`) are valid no later than the cycle in which `valid_out` is high.
- Latency count:
  - If `done_in` is first high N cycles after `valid_out` (N≥1), then `cycles_out` = N-1 once the block is back in IDLE.
  - `busy_out` falls the cycle after `done_in`.
- Back-to-back frames: a SYNC strobed in the cycle after RUN exit is accepted.
- Reset asserted mid-frame or mid-RUN returns the block to IDLE on the next edge and clears all outputs. Any `done_in` arriving afterward is ignored.
- Host pacing: at most one word per cycle is captured. Consecutive `seq_in` toggles on adjacent cycles are each captured.

## Test plan
Run all scenarios with DIM=4.
- Basic frame: strobe SYNC, 5, 7, 1, 1, 4, 9. Required response:
  - `valid_out` pulses once, one cycle after the last strobe.
  - `query_out` = {5, 7, 1, 1}, `k_out` = 4, `vertex_id_out` = 9.
  - `done_in` pulsed 20 cycles after launch gives `cycles_out` = 19 and `busy_out` = 0.
- Mid-frame resync: strobe SYNC, 3, 3, then SYNC, 8, 8, 8, 8, 2, 6. Required response: exactly one `valid_out`, with `query_out` = {8, 8, 8, 8}, `k_out` = 2, `vertex_id_out` = 6.
- Ignored traffic:
  - Data strobes in IDLE produce no `valid_out`.
  - A full SYNC frame strobed during RUN produces no `valid_out`, and the outputs stay unchanged.
  - `done_in` pulsed in IDLE leaves `cycles_out` unchanged.
- Strobe edge cases:
  - Releasing reset with `seq_in`=1 gives no capture.
  - `seq_in` toggling on every cycle captures every word.
  - Repeated identical `word_in` values, each with its own toggle, are all captured.
- Reset mid-RUN: assert `rst_in` 5 cycles after launch. Required response:
  - All outputs are 0 and the state is IDLE.
  - A later `done_in` has no effect.
  - A new full frame launches normally.
- Saturation: force a long RUN past 2^32 cycles, or run a DUT variant with a narrowed counter. `cycles_out` holds at its maximum value and does not wrap.
